// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: arbitrates fetch and data ports onto one async SRAM
// bank with registered strobes and parametrised read/write wait states.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   if_req/if_addr       fetch request (always a read) and byte address
//   if_rdata/if_ack      fetch read data and one-cycle completion pulse
//   mem_req/mem_we       data request, 1 = write
//   mem_addr/mem_sel     data byte address, write byte lanes
//   mem_wdata            write data
//   mem_rdata/mem_ack    data read data and one-cycle completion pulse
//   busy                 an access is in progress
//   sram_addr            SRAM word address
//   sram_dout/sram_doe   bus drive value and enable (tristate at top)
//   sram_din             bus sample
//   sram_be_n/ce_n/oe_n/we_n  active-low SRAM strobes
module sram_bus_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2,
  parameter int FAIR       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dout,
  output logic              sram_doe,
  input  logic [31:0]       sram_din,
  output logic [3:0]        sram_be_n,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  localparam int MAX_W =
    (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic FAIR_EN = (FAIR != 0);

  state_t            state, nxt_state;
  logic [CNT_W-1:0]  cnt, nxt_cnt;
  logic              gnt_mem, nxt_gnt_mem;
  logic              last_mem, nxt_last_mem;
  logic [ADDR_W-1:0] nxt_addr;
  logic [31:0]       nxt_dout;
  logic [3:0]        nxt_be_n;
  logic              nxt_ce_n, nxt_oe_n, nxt_we_n, nxt_doe;
  logic [31:0]       nxt_if_rdata, nxt_mem_rdata;
  logic              nxt_if_ack, nxt_mem_ack;
  logic              grant, pick_mem;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  // An ack cycle still sees the requester's req high; granting then
  // would serve the same request twice.
  assign grant = (if_req | mem_req) & ~if_ack & ~mem_ack;
  assign pick_mem = mem_req & (~if_req | ~FAIR_EN | ~last_mem);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt_mem   <= 1'b0;
      last_mem  <= 1'b0;
      sram_addr <= '0;
      sram_dout <= '0;
      sram_be_n <= 4'hF;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_doe  <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      gnt_mem   <= nxt_gnt_mem;
      last_mem  <= nxt_last_mem;
      sram_addr <= nxt_addr;
      sram_dout <= nxt_dout;
      sram_be_n <= nxt_be_n;
      sram_ce_n <= nxt_ce_n;
      sram_oe_n <= nxt_oe_n;
      sram_we_n <= nxt_we_n;
      sram_doe  <= nxt_doe;
      if_rdata  <= nxt_if_rdata;
      mem_rdata <= nxt_mem_rdata;
      if_ack    <= nxt_if_ack;
      mem_ack   <= nxt_mem_ack;
    end
  end

  always_comb begin
    nxt_state     = state;
    nxt_cnt       = cnt;
    nxt_gnt_mem   = gnt_mem;
    nxt_last_mem  = last_mem;
    nxt_addr      = sram_addr;
    nxt_dout      = sram_dout;
    nxt_be_n      = sram_be_n;
    nxt_ce_n      = sram_ce_n;
    nxt_oe_n      = sram_oe_n;
    nxt_we_n      = sram_we_n;
    nxt_doe       = sram_doe;
    nxt_if_rdata  = if_rdata;
    nxt_mem_rdata = mem_rdata;
    nxt_if_ack    = 1'b0;
    nxt_mem_ack   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant) begin
          nxt_gnt_mem  = pick_mem;
          nxt_last_mem = pick_mem;
          nxt_ce_n     = 1'b0;
          if (pick_mem && mem_we) begin
            nxt_state = WR_SETUP;
            nxt_addr  = mem_addr[ADDR_W+1:2];
            nxt_dout  = mem_wdata;
            nxt_be_n  = ~mem_sel;
            nxt_doe   = 1'b1;
          end else begin
            nxt_state = RD;
            nxt_addr  = pick_mem ? mem_addr[ADDR_W+1:2]
                                 : if_addr[ADDR_W+1:2];
            nxt_be_n  = 4'h0;
            nxt_oe_n  = 1'b0;
            nxt_cnt   = RD_LOAD;
          end
        end
      end
      RD: begin
        if (cnt == '0) begin
          nxt_state = IDLE;
          nxt_ce_n  = 1'b1;
          nxt_oe_n  = 1'b1;
          nxt_be_n  = 4'hF;
          if (gnt_mem) begin
            nxt_mem_rdata = sram_din;
            nxt_mem_ack   = 1'b1;
          end else begin
            nxt_if_rdata = sram_din;
            nxt_if_ack   = 1'b1;
          end
        end else begin
          nxt_cnt = cnt - CNT_ONE;
        end
      end
      WR_SETUP: begin
        // No lanes enabled: keep we_n high and go straight to hold.
        if (sram_be_n == 4'hF) begin
          nxt_state = WR_HOLD;
        end else begin
          nxt_state = WR_PULSE;
          nxt_we_n  = 1'b0;
          nxt_cnt   = WR_LOAD;
        end
      end
      WR_PULSE: begin
        if (cnt == '0) begin
          nxt_state = WR_HOLD;
          nxt_we_n  = 1'b1;
        end else begin
          nxt_cnt = cnt - CNT_ONE;
        end
      end
      WR_HOLD: begin
        nxt_state   = IDLE;
        nxt_ce_n    = 1'b1;
        nxt_oe_n    = 1'b1;
        nxt_we_n    = 1'b1;
        nxt_be_n    = 4'hF;
        nxt_doe     = 1'b0;
        nxt_mem_ack = 1'b1;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: random and directed stimulus against a
// transaction-level model of arbitration, latency and memory contents.
module tb_sram_bus_arbiter;

  localparam int AW = 20;
  localparam int RW = 2;
  localparam int WW = 2;
  localparam bit FAIR = 1'b1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic [31:0]   if_rdata;
  logic          if_ack;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [31:0]   mem_addr = '0;
  logic [3:0]    mem_sel = '0;
  logic [31:0]   mem_wdata = '0;
  logic [31:0]   mem_rdata;
  logic          mem_ack;
  logic          busy;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_dout;
  logic          sram_doe;
  logic [31:0]   sram_din;
  logic [3:0]    sram_be_n;
  logic          sram_ce_n, sram_oe_n, sram_we_n;

  sram_bus_arbiter #(
    .ADDR_W(AW), .READ_WAIT(RW), .WRITE_WAIT(WW), .FAIR(1)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy),
    .sram_addr(sram_addr), .sram_dout(sram_dout),
    .sram_doe(sram_doe), .sram_din(sram_din),
    .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  logic [31:0] smem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] junk = '0;

  assign sram_din = (!sram_ce_n && !sram_oe_n)
                  ? smem[sram_addr[3:0]] : junk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old,
                                        logic [31:0] nw,
                                        logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    return $urandom & 32'hFFC0_003F;
  endfunction

  // Transaction model: an access occupies the bank for a fixed number
  // of edges, then acks for one cycle, during which nothing is granted.
  logic          m_active = 1'b0;
  logic          m_mem = 1'b0;
  logic          m_wr = 1'b0;
  logic          m_blk = 1'b0;
  logic          last_mem = 1'b0;
  logic [AW-1:0] m_word = '0;
  logic [31:0]   m_wdata = '0;
  logic [3:0]    m_sel = '0;
  logic [31:0]   m_a = '0;
  int            m_left = 0;
  logic          e_if_ack = 1'b0, e_mem_ack = 1'b0;
  logic [31:0]   e_if_rdata = '0, e_mem_rdata = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_left = 0;
      last_mem = 1'b0;
      e_if_ack = 1'b0;
      e_mem_ack = 1'b0;
      e_if_rdata = '0;
      e_mem_rdata = '0;
    end else begin
      m_blk = e_if_ack | e_mem_ack;
      e_if_ack = 1'b0;
      e_mem_ack = 1'b0;
      if (m_active) begin
        m_left--;
        if (m_left == 0) begin
          m_active = 1'b0;
          if (m_mem) e_mem_ack = 1'b1;
          else e_if_ack = 1'b1;
          if (!m_wr && m_mem) e_mem_rdata = ref_mem[m_word[3:0]];
          if (!m_wr && !m_mem) e_if_rdata = ref_mem[m_word[3:0]];
        end
      end else if (!m_blk && (if_req || mem_req)) begin
        if (if_req && mem_req) m_mem = FAIR ? !last_mem : 1'b1;
        else m_mem = mem_req;
        last_mem = m_mem;
        m_a = m_mem ? mem_addr : if_addr;
        m_word = m_a[AW+1:2];
        m_wr = m_mem && mem_we;
        m_sel = mem_sel;
        m_wdata = mem_wdata;
        if (!m_wr) m_left = RW;
        else if (m_sel == 4'h0) m_left = 2;
        else m_left = WW + 2;
        m_active = 1'b1;
      end
    end
  end

  int   p_if = 0, p_mem = 0;
  logic if_seen = 1'b0, mem_seen = 1'b0;
  logic prev_act = 1'b0, prev_doe = 1'b0;
  int   wlow = 0, olow = 0;
  bit   ack_q [$];

  task automatic step();
    logic [3:0] e_be;
    @(negedge clk);
    junk = $urandom;
    if (m_active && !prev_act) begin
      wlow = 0;
      olow = 0;
    end
    if (!sram_we_n) begin
      wlow++;
      chk("we_after_doe", 32'(prev_doe), 32'd1);
    end
    if (!sram_oe_n) olow++;
    chk("if_ack", 32'(if_ack), 32'(e_if_ack));
    chk("mem_ack", 32'(mem_ack), 32'(e_mem_ack));
    chk("busy", 32'(busy), 32'(m_active));
    chk("ce_n", 32'(sram_ce_n), 32'(!m_active));
    chk("oe_n", 32'(sram_oe_n), 32'(!(m_active && !m_wr)));
    chk("doe", 32'(sram_doe), 32'(m_active && m_wr));
    if (!m_active) e_be = 4'hF;
    else if (m_wr) e_be = ~m_sel;
    else e_be = 4'h0;
    chk("be_n", 32'(sram_be_n), 32'(e_be));
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("mem_rdata", mem_rdata, e_mem_rdata);
    if (m_active) chk("sram_addr", 32'(sram_addr), 32'(m_word));
    if (m_active && m_wr) chk("sram_dout", sram_dout, m_wdata);
    if (e_mem_ack && m_wr) begin
      ref_mem[m_word[3:0]] =
        merge(ref_mem[m_word[3:0]], m_wdata, m_sel);
      chk("we_cycles", 32'(wlow), (m_sel == 4'h0) ? 32'd0 : 32'(WW));
      chk("sram_word", smem[m_word[3:0]], ref_mem[m_word[3:0]]);
    end
    if ((e_mem_ack || e_if_ack) && !m_wr)
      chk("oe_cycles", 32'(olow), 32'(RW));
    if (!sram_ce_n && !sram_we_n)
      smem[sram_addr[3:0]] =
        merge(smem[sram_addr[3:0]], sram_dout, ~sram_be_n);
    prev_act = m_active;
    prev_doe = sram_doe;
    if (if_ack) ack_q.push_back(1'b0);
    if (mem_ack) ack_q.push_back(1'b1);
    if (if_req && if_seen) if_req = 1'b0;
    if (!if_req && !rst && $urandom_range(99) < p_if) begin
      if_req = 1'b1;
      if_addr = rand_addr();
    end else if (!if_req) begin
      if_addr = $urandom;
    end
    if (mem_req && mem_seen) mem_req = 1'b0;
    if (!mem_req && !rst && $urandom_range(99) < p_mem) begin
      mem_req = 1'b1;
      mem_we = 1'($urandom);
      mem_addr = rand_addr();
      mem_sel = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom);
      mem_wdata = $urandom;
    end else if (!mem_req) begin
      mem_addr = $urandom;
      mem_wdata = $urandom;
    end
    if_seen = if_ack;
    mem_seen = mem_ack;
  endtask

  task automatic wait_ack(input bit port, input int budget,
                          output int n);
    n = 0;
    while (1) begin
      step();
      n++;
      if (port ? mem_seen : if_seen) break;
      if (n >= budget) begin
        chk("ack_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((if_req || mem_req || busy) && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) chk("drain_timeout", 32'd0, 32'd1);
    step();
    step();
  endtask

  int          n;
  int          lowcnt;
  logic [31:0] old;

  initial begin
    for (int i = 0; i < 16; i++) begin
      smem[i] = $urandom;
      ref_mem[i] = smem[i];
    end
    repeat (6) begin
      step();
      if_req = 1'($urandom);
      mem_req = 1'($urandom);
      mem_we = 1'($urandom);
      mem_addr = $urandom;
      if_addr = $urandom;
    end
    if_req = 1'b0;
    mem_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();

    p_if = 100;
    p_mem = 100;
    ack_q.delete();
    n = 0;
    while (ack_q.size() < 4 && n < 80) begin
      step();
      n++;
    end
    chk("tie_acks", 32'(ack_q.size()), 32'd4);
    if (ack_q.size() >= 4) begin
      chk("tie0_mem", 32'(ack_q[0]), 32'd1);
      chk("tie1_if", 32'(ack_q[1]), 32'd0);
      chk("tie2_mem", 32'(ack_q[2]), 32'd1);
      chk("tie3_if", 32'(ack_q[3]), 32'd0);
    end
    p_if = 0;
    p_mem = 0;
    drain();

    smem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    if_addr = 32'h0000_0010;
    if_req = 1'b1;
    wait_ack(1'b0, 20, n);
    chk("fetch_lat", 32'(n), 32'(RW + 1));
    chk("fetch_data", if_rdata, 32'hDEADBEEF);
    drain();

    old = smem[2];
    mem_we = 1'b1;
    mem_addr = 32'h0000_0008;
    mem_sel = 4'b0010;
    mem_wdata = 32'h11223344;
    mem_req = 1'b1;
    wait_ack(1'b1, 20, n);
    chk("write_lat", 32'(n), 32'(WW + 3));
    chk("byte_write", smem[2], {old[31:16], 8'h33, old[7:0]});
    drain();

    old = smem[3];
    mem_we = 1'b1;
    mem_addr = 32'h0000_000C;
    mem_sel = 4'b0000;
    mem_wdata = 32'hCAFEF00D;
    mem_req = 1'b1;
    wait_ack(1'b1, 20, n);
    chk("sel0_lat", 32'(n), 32'd3);
    chk("sel0_word", smem[3], old);
    drain();

    mem_we = 1'b1;
    mem_addr = 32'h0000_0014;
    mem_sel = 4'hF;
    mem_wdata = $urandom;
    mem_req = 1'b1;
    lowcnt = 0;
    n = 0;
    while (lowcnt < 2 && n < 20) begin
      step();
      n++;
      if (!sram_we_n) lowcnt++;
    end
    chk("pulse2_seen", 32'(lowcnt), 32'd2);
    rst = 1'b1;
    #1;
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_doe", 32'(sram_doe), 32'd0);
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(mem_ack), 32'd0);
    step();
    step();
    rst = 1'b0;
    wait_ack(1'b1, 20, n);
    chk("regrant_lat", 32'(n), 32'(WW + 3));
    drain();

    p_if = 30;
    p_mem = 30;
    repeat (3000) step();
    p_if = 0;
    p_mem = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Synchronous arbiter and timing controller placing the CPU instruction-fetch port and data-memory port onto one asynchronous 32-bit SRAM bank.
- Serialises the two requesters with a req/ack handshake.
- Generates registered, glitch-free SRAM strobes with parametrised wait states.
- Drives the data bus through separate out/enable/in signals; the top level owns the tristate buffer.
- Replaces the purely combinational address mux between fetch and data access.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width; word address = byte address [ADDR_W+1:2]
- READ_WAIT, 2, cycles the read strobe is held before data capture (≥1)
- WRITE_WAIT, 2, cycles we_n is held low (≥1)
- FAIR, 1, 0 = data port always wins; 1 = round-robin when both ports request

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetch read data, valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse
- mem_req  in  1  data request, held until mem_ack
- mem_we  in  1  1 = write
- mem_addr  in  32  data byte address
- mem_sel  in  4  byte lanes for writes
- mem_wdata  in  32  write data
- mem_rdata  out  32  read data, valid while mem_ack=1
- mem_ack  out  1  one-cycle completion pulse
- busy  out  1  state ≠ IDLE
- sram_addr  out  ADDR_W  word address
- sram_dout  out  32  data to drive onto the bus
- sram_doe  out  1  bus drive enable
- sram_din  in  32  bus sample
- sram_be_n / sram_ce_n / sram_oe_n / sram_we_n  out  4/1/1/1  SRAM strobes, active low

## Operation
- States:
  - IDLE
  - RD: READ_WAIT cycles
  - WR_SETUP: 1 cycle
  - WR_PULSE: WRITE_WAIT cycles
  - WR_HOLD: 1 cycle
- All SRAM outputs, acks and rdata are registered.
- Grant in IDLE at a clock edge:
  - Only when at least one req is high and neither ack is high in that cycle. A requester still holds req during its ack cycle; this rule prevents a double grant.
  - Only one port requesting: that port wins.
  - Both requesting, FAIR=0: the data port wins.
  - Both requesting, FAIR=1: the port not granted last wins. The last-granted pointer resets to "fetch", so the data port wins the first tie.
- On grant:
  - Latch sram_addr and, for writes, sram_dout and be_n = ~mem_sel.
  - Fetches are always reads.
- RD:
  - ce_n=0, oe_n=0, we_n=1, be_n=0000, doe=0.
  - At the edge ending the last RD cycle, sram_din is captured into the granted port's rdata, its ack is set and the state returns to IDLE.
- Write:
  - WR_SETUP: ce_n=0, oe_n=1, we_n=1, doe=1.
  - WR_PULSE: we_n=0.
  - WR_HOLD: we_n=1, doe=1, ce_n=0.
  - Then mem_ack is set and the state returns to IDLE.
- Write with mem_sel=0000: skip WR_PULSE (we_n never falls); SETUP → HOLD → ack.
- Address bits above ADDR_W+1 and bits [1:0] are ignored (wrap-around).
- Returning to IDLE drives ce_n=1, oe_n=1, be_n=1111 and doe=0. sram_addr and sram_dout hold their last value.
- rdata holds its value between acks. The ungranted port's rdata is unchanged.

## Timing
- Reset values: ce_n=1, oe_n=1, we_n=1, be_n=1111, doe=0, sram_addr=0, sram_dout=0, both rdata=0, both acks=0, busy=0, state IDLE.
- rst asserted mid-access: reset values apply immediately and asynchronously. The interrupted access gets no ack.
- Read latency: request sampled at edge E0 → ack high in the cycle after edge E0+READ_WAIT.
- Write latency: ack high in the cycle after edge E0+WRITE_WAIT+2, or E0+2 when sel=0000.
- Back-to-back: the next grant is at the edge ending the ack cycle. One idle-strobe cycle separates accesses, which guarantees ce_n/we_n recovery.
- Address and data are stable for the whole WR_PULSE; we_n never falls in the same cycle that doe rises.
- A req dropped before ack is a protocol violation; the access still completes and acks.

## Test plan
- Reset: hold rst, apply toggling inputs → all outputs at reset values; release → IDLE, busy=0.
- Single fetch, READ_WAIT=2: if_addr=0x0000_0010, sram_din=0xDEADBEEF → sram_addr=4, oe_n low 2 cycles; if_ack pulses once with if_rdata=0xDEADBEEF, 3 cycles after the grant edge.
- Byte write: mem_addr=0x0000_0008, sel=0010, wdata=0x11223344, WRITE_WAIT=2 → be_n=1101, we_n low exactly 2 cycles, doe high 4 cycles, mem_ack after 4; a sel=0000 write shows no we_n pulse and acks after 2.
- Contention, FAIR=1: both ports request continuously → grants alternate mem, if, mem, if; with FAIR=0, if_ack never fires while mem_req stays high.
- Handshake: requester holds req through ack → exactly one ack per request, no duplicate grant.
- Async reset asserted in the 2nd WR_PULSE cycle → we_n=1 and doe=0 before the next edge, no mem_ack; after release, the pending request is re-granted from IDLE.
